// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_ctrl
// Description : Hack CPU fetch/branch sequencer. Drives the PC block, fetches
//               over req/ack, issues to the datapath over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl #(
    parameter int WIDTH             = 16,
    parameter int CNT_W             = 16,
    parameter bit HALT_ON_SELF_JUMP = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pc_out,
    output logic             pc_reset,
    output logic             pc_load,
    output logic             pc_inc,
    output logic [WIDTH-1:0] pc_in,
    output logic [WIDTH-1:0] imem_addr,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] ir,
    output logic             exec_valid,
    input  logic             exec_ready,
    input  logic             alu_zr,
    input  logic             alu_ng,
    input  logic [WIDTH-1:0] a_reg,
    input  logic             restart,
    output logic             halted,
    output logic             wrap_err,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_UPDATE = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             taken_q;
    logic             taken_now;
    logic             self_jump;
    logic [CNT_W-1:0] retired_inc;

    // Hack jump decode: only C-instructions (111x...) can branch.
    always_comb begin
        taken_now = 1'b0;
        if (ir[15:13] == 3'b111) begin
            taken_now = (ir[2] & alu_ng) | (ir[1] & alu_zr) | (ir[0] & ~alu_ng & ~alu_zr);
        end
    end

    assign self_jump   = HALT_ON_SELF_JUMP && taken_now && (a_reg == pc_out);
    assign retired_inc = (retired == {CNT_W{1'b1}}) ? retired : retired + CNT_W'(1);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH:  if (imem_ack) state_nxt = S_EXEC;
            S_EXEC:   if (exec_ready) state_nxt = self_jump ? S_HALT : S_UPDATE;
            S_UPDATE: state_nxt = S_FETCH;
            S_HALT:   if (restart) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            ir       <= '0;
            pc_in    <= '0;
            taken_q  <= 1'b0;
            retired  <= '0;
            wrap_err <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_FETCH: begin
                    if (imem_ack) ir <= instr;
                end
                S_EXEC: begin
                    if (exec_ready) begin
                        taken_q <= taken_now;
                        pc_in   <= a_reg;
                        // A halting self-jump still counts as a completed instruction.
                        if (self_jump) retired <= retired_inc;
                    end
                end
                S_UPDATE: begin
                    retired <= retired_inc;
                    if (!taken_q && (pc_out == {WIDTH{1'b1}})) wrap_err <= 1'b1;
                end
                S_HALT: begin
                    if (restart) wrap_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Moore outputs; reset forces IDLE so pc_reset is high throughout reset.
    assign pc_reset   = (state == S_IDLE);
    assign imem_req   = (state == S_FETCH);
    assign exec_valid = (state == S_EXEC);
    assign pc_load    = (state == S_UPDATE) &&  taken_q;
    assign pc_inc     = (state == S_UPDATE) && !taken_q;
    assign halted     = (state == S_HALT);
    assign imem_addr  = pc_out;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_ctrl
// Description : Bench for pc_fetch_ctrl with a PC block model and a
//               transaction-level reference of the jump/retire rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_ctrl;

    localparam int WIDTH   = 16;
    localparam int CNT_W   = 4;
    localparam int RET_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [WIDTH-1:0] pc_out;
    logic             pc_reset, pc_load, pc_inc;
    logic [WIDTH-1:0] pc_in, imem_addr, ir;
    logic             imem_req, exec_valid, halted, wrap_err;
    logic             imem_ack = 1'b0, exec_ready = 1'b0, restart = 1'b0;
    logic             alu_zr = 1'b0, alu_ng = 1'b0;
    logic [WIDTH-1:0] instr = '0, a_reg = '0;
    logic [CNT_W-1:0] retired;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] m_pc;
    int               m_ret;
    bit               m_wrap;
    logic [WIDTH-1:0] pc_model;

    pc_fetch_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .HALT_ON_SELF_JUMP(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .pc_out(pc_out),
        .pc_reset(pc_reset), .pc_load(pc_load), .pc_inc(pc_inc), .pc_in(pc_in),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .instr(instr),
        .ir(ir), .exec_valid(exec_valid), .exec_ready(exec_ready),
        .alu_zr(alu_zr), .alu_ng(alu_ng), .a_reg(a_reg), .restart(restart),
        .halted(halted), .wrap_err(wrap_err), .retired(retired)
    );

    always #5 clk = ~clk;

    // PC block the controller drives.
    always @(posedge clk) begin
        if (pc_reset)     pc_model <= '0;
        else if (pc_load) pc_model <= pc_in;
        else if (pc_inc)  pc_model <= pc_model + 16'd1;
    end
    assign pc_out = pc_model;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ALU result sign: -1 negative, 0 zero, +1 positive.
    function automatic bit ref_taken(input logic [15:0] ins, input int sgn);
        logic [2:0] j;
        if (ins[15:13] != 3'b111) return 1'b0;
        j = ins[2:0];
        case (j)
            3'd0: return 1'b0;
            3'd1: return sgn > 0;
            3'd2: return sgn == 0;
            3'd3: return sgn >= 0;
            3'd4: return sgn < 0;
            3'd5: return sgn != 0;
            3'd6: return sgn <= 0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic run_instr(input logic [15:0] ins, input logic [15:0] a, input int sgn,
                             input int ack_w, input int rdy_w, output bit hlt);
        bit tk;
        logic [31:0] r;
        check("fetch_req", imem_req, 1);
        check("fetch_addr", imem_addr, m_pc);
        for (int i = 0; i < ack_w; i++) begin
            imem_ack = 1'b0;
            r = $urandom;
            restart = r[0];
            tick();
            check("req_hold", imem_req, 1);
            check("fetch_no_strobe", {pc_reset, pc_load, pc_inc, exec_valid}, 0);
        end
        restart  = 1'b0;
        imem_ack = 1'b1;
        instr    = ins;
        tick();
        imem_ack = 1'b0;
        instr    = 16'(($urandom));
        check("exec_valid", exec_valid, 1);
        check("ir", ir, ins);
        check("req_drop", imem_req, 0);
        for (int i = 0; i < rdy_w; i++) begin
            exec_ready = 1'b0;
            a_reg = 16'($urandom);
            tick();
            check("valid_hold", exec_valid, 1);
            check("exec_no_strobe", {pc_reset, pc_load, pc_inc, imem_req}, 0);
        end
        exec_ready = 1'b1;
        a_reg  = a;
        alu_zr = (sgn == 0);
        alu_ng = (sgn < 0);
        tick();
        exec_ready = 1'b0;
        alu_zr = 1'b0;
        alu_ng = 1'b0;
        tk  = ref_taken(ins, sgn);
        hlt = tk && (a == m_pc);
        if (m_ret < RET_MAX) m_ret++;
        if (hlt) begin
            check("halt_flag", halted, 1);
            check("halt_no_strobe", {pc_reset, pc_load, pc_inc, imem_req, exec_valid}, 0);
            check("halt_retired", retired, m_ret);
            return;
        end
        check("upd_load", pc_load, tk);
        check("upd_inc", pc_inc, !tk);
        check("upd_no_reset", pc_reset, 0);
        if (tk) check("upd_pc_in", pc_in, a);
        if (!tk && m_pc == 16'hFFFF) m_wrap = 1'b1;
        m_pc = tk ? a : m_pc + 16'd1;
        tick();
        check("retired", retired, m_ret);
        check("wrap_err", wrap_err, m_wrap);
        check("next_addr", imem_addr, m_pc);
        check("next_req", imem_req, 1);
        check("not_halted", halted, 0);
    endtask

    task automatic do_restart();
        tick();
        check("halt_stays", halted, 1);
        check("halt_ret_hold", retired, m_ret);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("rst_pulse", pc_reset, 1);
        check("rst_unhalt", halted, 0);
        check("rst_wrap_clr", wrap_err, 0);
        m_wrap = 1'b0;
        m_pc   = '0;
        tick();
        check("rst_fetch", imem_req, 1);
        check("rst_addr", imem_addr, 0);
    endtask

    initial begin
        bit          h;
        logic [31:0] r;
        logic [15:0] ins, a;
        int          sgn;

        // Reset held two cycles, then one pc_reset cycle, then FETCH at 0.
        tick();
        tick();
        check("rst_pc_reset", pc_reset, 1);
        check("rst_outs", {imem_req, exec_valid, pc_load, pc_inc, halted, wrap_err}, 0);
        check("rst_retired", retired, 0);
        check("rst_ir", ir, 0);
        check("rst_pc_in", pc_in, 0);
        reset_n = 1'b1;
        check("post_rst_pulse", pc_reset, 1);
        tick();
        m_pc = '0; m_ret = 0; m_wrap = 1'b0;
        check("post_rst_req", imem_req, 1);
        check("post_rst_nopulse", pc_reset, 0);

        run_instr(16'h00FF, 16'h1234, 1, 0, 0, h);
        run_instr(16'hE302, 16'h0010, 0, 0, 0, h);
        run_instr(16'hE302, 16'h0010, 1, 0, 0, h);
        run_instr(16'hEA87, 16'h0005, 1, 0, 0, h);
        run_instr(16'hEA87, 16'h0005, 1, 0, 0, h);
        check("self_jump_halt", h, 1);
        do_restart();
        run_instr(16'h0042, 16'h0000, -1, 4, 3, h);

        // Reset asserted mid-EXEC.
        imem_ack = 1'b1;
        instr = 16'hE307;
        tick();
        imem_ack = 1'b0;
        check("pre_rst_exec", exec_valid, 1);
        reset_n = 1'b0;
        #1;
        check("async_valid_drop", exec_valid, 0);
        check("async_pc_reset", pc_reset, 1);
        check("async_retired", retired, 0);
        check("async_ir", ir, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        m_pc = '0; m_ret = 0; m_wrap = 1'b0;
        check("rerun_req", imem_req, 1);
        check("rerun_addr", imem_addr, 0);

        // Wrap from all-ones stays sticky until restart.
        run_instr(16'hEA87, 16'hFFFF, 1, 0, 0, h);
        run_instr(16'h0001, 16'h0000, 1, 1, 0, h);
        run_instr(16'h0002, 16'h0003, 0, 0, 1, h);

        for (int n = 0; n < 300; n++) begin
            r = $urandom;
            case (r[1:0])
                2'd0: ins = {1'b0, r[16:2]};
                2'd1: ins = {3'b111, r[14:2]};
                2'd2: ins = {3'b111, r[11:2], r[20:18] | 3'b010};
                default: ins = {(r[9:8] == 2'd0) ? 3'b110 : {2'b10, r[10]}, r[22:10]};
            endcase
            r = $urandom;
            a = (r[2:0] == 3'd0) ? m_pc : r[31:16];
            sgn = int'($urandom_range(0, 2)) - 1;
            run_instr(ins, a, sgn, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), h);
            if (h) do_restart();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
